// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and timing constants.
// Reused by the transmitter scheduler and a future receiver.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 10416;
  localparam int FRAME_BITS       = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Restarts from zero on clear and after every terminal count.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin UART transmitter, 8N1, LSB first.
// Grant, byte capture and start bit all happen on one IDLE edge.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       done
);

  uart_state_e state_q;
  uart_state_e state_d;

  logic [7:0] sh_q;
  logic [7:0] sh_d;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic       tx_q;
  logic       tx_d;
  logic       busy_q;
  logic       busy_d;
  logic       gid_q;
  logic       gid_d;
  logic       last_q;
  logic       last_d;
  logic       ack0_q;
  logic       ack0_d;
  logic       ack1_q;
  logic       ack1_d;

  logic grant;
  logic pick;
  logic bit_end;

  assign grant = (state_q == IDLE) && (req0 || req1);

  // On a tie, serve whoever did not go last.
  always_comb begin
    pick = 1'b0;
    unique case ({req1, req0})
      2'b11:   pick = ~last_q;
      2'b10:   pick = 1'b1;
      default: pick = 1'b0;
    endcase
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (grant),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    gid_d   = gid_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = START;
          sh_d    = pick ? data1 : data0;
          idx_d   = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          gid_d   = pick;
          last_d  = pick;
          ack0_d  = ~pick;
          ack1_d  = pick;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign done     = (state_q == STOP) && bit_end;

endmodule
